// File: rtl/dct_transpose_pingpong_if.sv
// Row/column handshake bundle between the row-pass DCT, the transpose buffer
// and the column-pass DCT.
interface dct_transpose_pingpong_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH*8-1:0] row_in;
    logic                    row_valid;
    logic                    row_ready;
    logic [DATA_WIDTH*8-1:0] col_out;
    logic                    col_valid;
    logic                    col_ready;
    logic                    block_done;

    modport master (
        output row_in,
        output row_valid,
        output col_ready,
        input  row_ready,
        input  col_out,
        input  col_valid,
        input  block_done
    );

    modport slave (
        input  row_in,
        input  row_valid,
        input  col_ready,
        output row_ready,
        output col_out,
        output col_valid,
        output block_done
    );
endinterface

// File: rtl/dct_transpose_pingpong.sv
// Double-buffered 8x8 transpose: rows fill one bank while the other bank
// drains column by column to the column-pass DCT.
module dct_transpose_pingpong #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    dct_transpose_pingpong_if.slave   xfer_if
);

    // Storage is deliberately not reset; full_q gates every read of it.
    logic [DATA_WIDTH-1:0] mem_q [2][8][8];

    logic [1:0] full_q;
    logic [1:0] full_d;
    logic       wr_bank_q;
    logic       wr_bank_d;
    logic [2:0] wr_row_q;
    logic [2:0] wr_row_d;
    logic       rd_bank_q;
    logic       rd_bank_d;
    logic [2:0] rd_col_q;
    logic [2:0] rd_col_d;
    logic       block_done_q;
    logic       block_done_d;

    logic                    row_ready_s;
    logic                    col_valid_s;
    logic                    row_accept_s;
    logic                    col_take_s;
    logic                    last_row_s;
    logic                    last_col_s;
    logic [1:0]              full_set_s;
    logic [1:0]              full_clr_s;
    logic [DATA_WIDTH*8-1:0] col_out_s;

    assign row_ready_s  = ~full_q[wr_bank_q];
    assign col_valid_s  = full_q[rd_bank_q];
    assign row_accept_s = xfer_if.row_valid & row_ready_s;
    assign col_take_s   = col_valid_s & xfer_if.col_ready;
    assign last_row_s   = row_accept_s & (wr_row_q == 3'd7);
    assign last_col_s   = col_take_s & (rd_col_q == 3'd7);

    // Accept and take always hit different banks, so set and clear never collide.
    assign full_set_s   = last_row_s ? (2'b01 << wr_bank_q) : 2'b00;
    assign full_clr_s   = last_col_s ? (2'b01 << rd_bank_q) : 2'b00;

    assign full_d       = (full_q | full_set_s) & ~full_clr_s;
    assign wr_row_d     = row_accept_s ? (wr_row_q + 3'd1) : wr_row_q;
    assign wr_bank_d    = wr_bank_q ^ last_row_s;
    assign rd_col_d     = col_take_s ? (rd_col_q + 3'd1) : rd_col_q;
    assign rd_bank_d    = rd_bank_q ^ last_col_s;
    assign block_done_d = last_col_s;

    // Control state: bank flags, row/column counters and the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q       <= 2'b00;
            wr_bank_q    <= 1'b0;
            wr_row_q     <= 3'd0;
            rd_bank_q    <= 1'b0;
            rd_col_q     <= 3'd0;
            block_done_q <= 1'b0;
        end else begin
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            wr_row_q     <= wr_row_d;
            rd_bank_q    <= rd_bank_d;
            rd_col_q     <= rd_col_d;
            block_done_q <= block_done_d;
        end
    end

    // Row write into the filling bank, element j to column j.
    always_ff @(posedge clk) begin
        if (row_accept_s) begin
            for (int j = 0; j < 8; j++) begin
                mem_q[wr_bank_q][wr_row_q][j] <= xfer_if.row_in[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Column read mux from the draining bank; forced to zero when nothing is full.
    always_comb begin
        col_out_s = '0;
        for (int r = 0; r < 8; r++) begin
            if (col_valid_s) begin
                col_out_s[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_bank_q][r][rd_col_q];
            end else begin
                col_out_s[r*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    assign xfer_if.row_ready  = row_ready_s;
    assign xfer_if.col_valid  = col_valid_s;
    assign xfer_if.col_out    = col_out_s;
    assign xfer_if.block_done = block_done_q;

endmodule

// File: tb/tb_dct_transpose_pingpong.sv
// Directed bench for the transpose buffer: the driver pushes the expected
// columns of each block once its 8th row is accepted; the monitor pops and compares.
module tb_dct_transpose_pingpong;

    localparam int DW = 32;
    localparam int VW = DW * 8;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    dct_transpose_pingpong_if #(.DATA_WIDTH(DW)) bus_if ();

    dct_transpose_pingpong #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .xfer_if (bus_if)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [VW-1:0] exp_q[$];
    logic [DW-1:0] blk[8][8];
    int            col_mode = 1;
    bit            mon_en   = 1'b0;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // col_ready source: 0 = held low, 1 = held high, 2 = random
    always @(negedge clk) begin
        case (col_mode)
            0:       bus_if.col_ready = 1'b0;
            1:       bus_if.col_ready = 1'b1;
            default: bus_if.col_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: column scoreboard, hold stability and block_done timing.
    logic [VW-1:0] prev_out;
    bit            prev_hold = 1'b0;
    int            take_cnt  = 0;
    bit            exp_done  = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (!reset_n || !mon_en) begin
            prev_hold = 1'b0;
            take_cnt  = 0;
            exp_done  = 1'b0;
        end else begin
            chk("block_done", VW'(bus_if.block_done), VW'(exp_done));
            if (prev_hold) begin
                chk("hold_valid", VW'(bus_if.col_valid), VW'(1));
                chk("hold_data", bus_if.col_out, prev_out);
            end
            exp_done = 1'b0;
            if (!bus_if.col_valid) chk("idle_col_out", bus_if.col_out, VW'(0));
            if (bus_if.col_valid && bus_if.col_ready) begin
                if (exp_q.size() == 0) chk("unexpected_column", VW'(bus_if.col_valid), VW'(0));
                else chk("column", bus_if.col_out, exp_q.pop_front());
                if (take_cnt == 7) begin
                    take_cnt = 0;
                    exp_done = 1'b1;
                end else begin
                    take_cnt++;
                end
            end
            prev_hold = bus_if.col_valid && !bus_if.col_ready;
            prev_out  = bus_if.col_out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [VW-1:0] row_vec(input int r);
        logic [VW-1:0] v;
        for (int j = 0; j < 8; j++) v[j*DW +: DW] = blk[r][j];
        return v;
    endfunction

    task automatic push_block();
        logic [VW-1:0] v;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 8; r++) v[r*DW +: DW] = blk[r][k];
            exp_q.push_back(v);
        end
    endtask

    task automatic fill_seq(input int base);
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) blk[r][j] = DW'(base + r*8 + j);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) blk[r][j] = $urandom;
    endtask

    task automatic fill_sign();
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) blk[r][j] = ((j + r) % 2 == 0) ? 32'hFFFF_FF80 : 32'h7FFF_FFFF;
    endtask

    // Present one row from the next negedge; returns after the accepting posedge.
    task automatic send_row(input logic [VW-1:0] v, output int waits);
        waits = 0;
        @(negedge clk);
        bus_if.row_valid = 1'b1;
        bus_if.row_in    = v;
        while (!bus_if.row_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!bus_if.row_ready) chk("row_wait_timeout", VW'(bus_if.row_ready), VW'(1));
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus_if.row_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_block(input bit stream_chk, input bit gaps, output int first_wait);
        int w;
        for (int r = 0; r < 8; r++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle();
            send_row(row_vec(r), w);
            if (r == 0) first_wait = w;
            if (stream_chk) chk("stream_row_ready", VW'(w), VW'(0));
        end
        push_block();
    endtask

    task automatic set_col_mode(input int m);
        @(posedge clk);
        col_mode = m;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        bus_if.row_valid = 1'b0;
        while ((exp_q.size() != 0 || bus_if.col_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", VW'(n < 500), VW'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_row_ready"},  VW'(bus_if.row_ready),  VW'(1));
        chk({tag, "_col_valid"},  VW'(bus_if.col_valid),  VW'(0));
        chk({tag, "_col_out"},    bus_if.col_out,         VW'(0));
        chk({tag, "_block_done"}, VW'(bus_if.block_done), VW'(0));
    endtask

    initial begin
        int w;
        reset_n          = 1'b0;
        bus_if.row_valid = 1'b0;
        bus_if.row_in    = '0;
        bus_if.col_ready = 1'b0;

        // Power-on reset
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_reset_outputs("reset");
        mon_en = 1'b1;

        // Single block with latency check on col_valid
        fill_seq(0);
        for (int r = 0; r < 8; r++) begin
            send_row(row_vec(r), w);
            #1;
            chk("latency_col_valid", VW'(bus_if.col_valid), VW'(r == 7));
        end
        push_block();
        wait_drain();

        // Four back-to-back blocks
        for (int b = 0; b < 4; b++) begin
            fill_seq(1000 + b*64);
            send_block(1'b1, 1'b0, w);
        end
        wait_drain();

        // Backpressure: two blocks fill both banks, the 17th row waits
        set_col_mode(0);
        fill_seq(2000);
        send_block(1'b0, 1'b0, w);
        fill_seq(3000);
        send_block(1'b0, 1'b0, w);
        #1;
        chk("bp_row_ready_low", VW'(bus_if.row_ready), VW'(0));
        col_mode = 1;
        fill_seq(4000);
        send_block(1'b0, 1'b0, w);
        chk("bp_row17_wait", VW'(w), VW'(8));
        wait_drain();

        // Random stalls on both sides
        set_col_mode(2);
        for (int b = 0; b < 10; b++) begin
            fill_rand();
            send_block(1'b0, 1'b1, w);
        end
        wait_drain();

        // Reset in the middle of a block
        set_col_mode(1);
        fill_seq(5000);
        for (int r = 0; r < 5; r++) send_row(row_vec(r), w);
        @(negedge clk);
        bus_if.row_valid = 1'b0;
        reset_n          = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_reset_outputs("postreset");
        fill_seq(100);
        send_block(1'b0, 1'b0, w);
        wait_drain();

        // Sign and full-width values
        fill_sign();
        send_block(1'b0, 1'b0, w);
        wait_drain();

        chk("scoreboard_empty", VW'(exp_q.size()), VW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_transpose_pingpong.md
# dct_transpose_pingpong

Double-buffered 8x8 transpose stage between the row-pass and column-pass 1-D DCT units of the 2-D DCT. It accepts eight row-DCT result vectors, one per handshake, and replays the block column by column to the column-pass unit. Two banks let the next block fill while the current block drains. Sustained throughput is one 8x8 block per 8 cycles.

## Interface
- DATA_WIDTH, 32, width of one signed coefficient; block size fixed at 8x8
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- row_in  in  DATA_WIDTH*8  one row vector; element j at bits [j*DATA_WIDTH +: DATA_WIDTH]
- row_valid  in  1  row_in holds a valid row
- row_ready  out  1  block can accept a row this cycle
- col_out  out  DATA_WIDTH*8  one column vector; element r (source row r) at bits [r*DATA_WIDTH +: DATA_WIDTH]
- col_valid  out  1  col_out holds a valid column
- col_ready  in  1  consumer takes col_out this cycle
- block_done  out  1  one-cycle pulse after the last column of a block is taken

## Operation
- Storage: two banks B0/B1, each 8x8 words of DATA_WIDTH bits. Words are copied bit-exact, with no sign or width change.
- Write side: registers wr_bank (1 b) and wr_row (3 b).
  - row_ready = !full[wr_bank].
  - Row accept = row_valid && row_ready. On accept, element j of row_in is written to M[wr_bank][wr_row][j] and wr_row increments.
  - On an accept with wr_row==7: full[wr_bank] is set, wr_bank toggles, and wr_row wraps to 0.
- Read side: registers rd_bank (1 b) and rd_col (3 b).
  - col_valid = full[rd_bank].
  - When col_valid=1, element r of col_out = M[rd_bank][r][rd_col].
  - When col_valid=0, col_out = 0.
  - col_out is a combinational mux of stable storage. It must not change while col_valid=1 and col_ready=0.
- Column take = col_valid && col_ready. On a take, rd_col increments.
- On a take with rd_col==7: full[rd_bank] clears, rd_bank toggles, rd_col wraps to 0, and block_done is registered high for the next cycle only.
- Ordering: blocks leave in arrival order. Bank order is B0, B1, B0, and so on.
- Simultaneous events:
  - A row accept and a column take in the same cycle always target different banks. A write requires !full and a read requires full, so both proceed.
  - A set and a clear of full[] on different banks in the same cycle both take effect.
- row_valid while row_ready=0: the row is not stored. The producer must hold it.
- Gaps in row_valid or col_ready are allowed at any point mid-block. Counters hold during gaps.
- Storage contents are not reset. After reset no bank is full, so stale data can never be output.

## Timing
- Reset values:
  - row_ready=1, col_valid=0, col_out=0, block_done=0.
  - wr_bank=rd_bank=0, wr_row=rd_col=0, full[1:0]=0.
- Reset mid-operation discards any partial or full blocks. The first row accepted after release is row 0 of a new block in B0.
- Latency: 8th row accepted at rising edge t gives col_valid=1 from edge t (visible in cycle t+1). The first column is available 1 cycle after the last row.
- Drain: with col_ready held high, the 8 columns leave in 8 consecutive cycles. block_done is high in the cycle after the 8th take.
- Full condition: both banks full gives row_ready=0. The column take that clears a bank at edge t raises row_ready from cycle t+1, not combinationally in the same cycle.
- No combinational path from row_valid to row_ready, or from col_ready to col_valid.

## Test plan
- Single block, col_ready=1: send rows with row r element j = r*8+j on 8 consecutive cycles. Required response:
  - col_valid rises 1 cycle after the 8th row.
  - Column k element r = r*8+k for k=0..7 on 8 consecutive cycles.
  - block_done pulses once, 1 cycle after column 7.
- Streaming, col_ready=1, 4 back-to-back blocks (64 consecutive rows):
  - row_ready never drops.
  - Each block's columns match its own data.
  - block_done pulses every 8 cycles.
- Backpressure, col_ready=0: send 17 rows.
  - row_ready drops after row 16; row 17 is held.
  - Then raise col_ready. Row 17 is accepted 1 cycle after the 8th column take of block 0.
  - Block 0 comes out before block 1 and both are intact.
- Stalls: toggle row_valid and col_ready pseudo-randomly for 10 blocks.
  - All columns match the transpose of their block.
  - col_out is stable whenever col_valid=1 and col_ready=0.
- Reset mid-block: accept 5 rows, pulse reset_n low for 1 cycle.
  - All outputs return to their reset values.
  - A new 8-row block (element = 100+r*8+j) outputs only new data; the first column is 100,108,...,156.
- Sign/width: a row of 32'hFFFF_FF80 and 32'h7FFF_FFFF alternating by j is returned bit-exact in the corresponding column elements.
